avalon_st_packet_arbiter: RTL and testbench
===========================================

AVALON_ST_PACKET_ARBITER -- requirements
Module: avalon_st_packet_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the per-port packet counters.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port in0  avalon_st_if.slave  (data/valid/sop/eop/empty/rdy)  SHALL be requester 0.
REQ-005 Port in1  avalon_st_if.slave  (same fields)  SHALL be requester 1.
REQ-006 Port arb_out  avalon_st_if.master  (same fields)  SHALL be the shared output stream.
REQ-007 Port stray_drop  output  1  SHALL pulse for one cycle per stray beat discarded (REQ-016).
REQ-008 Port pkt_cnt0  output  CNT_W  SHALL count packets completed from in0.
REQ-009 Port pkt_cnt1  output  CNT_W  SHALL count packets completed from in1.
REQ-010 Port busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 The arbiter SHALL use a three-state machine: IDLE, GRANT0, GRANT1.
REQ-012 A request from port i SHALL be in_i.valid & in_i.sop while in IDLE.
REQ-013 In IDLE with one request, the machine SHALL move to GRANT<i> on the next edge.
REQ-014 In IDLE with both requesting, the machine SHALL grant the port not recorded in last_grant; after reset last_grant SHALL be 1, so port 0 wins first.
REQ-015 In IDLE, arb_out.valid SHALL be 0, and in0.rdy/in1.rdy SHALL be 0 for requesting ports; the first beat SHALL be held upstream.
REQ-016 In IDLE, a valid beat without sop (stray) SHALL be accepted and discarded: rdy=1 for that port, stray_drop=1 for that cycle.
REQ-017 In GRANT<i>, arb_out data/valid/sop/eop/empty SHALL equal in_i combinationally, with in_i.rdy = arb_out.rdy.
REQ-018 In GRANT<i>, the non-granted port's rdy SHALL be 0.
REQ-019 Grant latency SHALL be exactly one cycle: a request in IDLE at cycle N SHALL appear on arb_out at cycle N+1.
REQ-020 A granted packet SHALL end on the beat with in_i.valid & arb_out.rdy & in_i.eop; on the next edge the machine SHALL return to IDLE, set last_grant=i, and increment pkt_cnt<i>.
REQ-021 A single-beat packet (sop & eop together) SHALL complete in one GRANT cycle under REQ-020.
REQ-022 Backpressure (arb_out.rdy=0) SHALL hold the state and grant indefinitely, with no beat lost or duplicated.
REQ-023 A valid & sop beat from the granted port mid-packet SHALL pass through unmodified; protocol checking is left to downstream enforcement.
REQ-024 Packet counters SHALL wrap modulo 2^CNT_W.
REQ-025 Arbitration SHALL occur only in IDLE; packets SHALL never interleave on arb_out.

Reset
REQ-026 While rst=0, the following SHALL hold: state=IDLE, last_grant=1, pkt_cnt0=pkt_cnt1=0, stray_drop=0, busy=0, arb_out.valid=0, in0.rdy=in1.rdy=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately, with no counter increment; after release, arbitration SHALL restart from IDLE.

Structure
REQ-028 The state enum (IDLE/GRANT0/GRANT1) and the port-count constant SHALL live in shared package avalon_arb_pkg.
REQ-029 Grant selection (requests + last_grant -> winner) SHALL be a sub-module avalon_arb_rr_picker, purely combinational.

Verification
REQ-030 Only in0 sends a 3-beat packet (sop at beat 1, eop at beat 3), rdy=1 -> beats appear on arb_out at cycles N+1..N+3; pkt_cnt0=1; busy low by N+4.
REQ-031 Both ports request in the same cycle, twice in a row -> port 0 is served first, then port 1, then port 0; counts end at pkt_cnt0=2 and pkt_cnt1=1 after three packets.
REQ-032 in1 sends a 4-beat packet with arb_out.rdy low for 5 cycles at beat 2 -> exactly 4 beats transferred in order; in0 rdy stays 0 throughout.
REQ-033 in0 drives valid without sop in IDLE for 2 cycles -> stray_drop pulses twice; arb_out.valid stays 0.
REQ-034 A single-beat packet on in1 (sop=eop=1, empty=3) -> one output beat carrying empty=3; pkt_cnt1 increments; state returns to IDLE.
REQ-035 rst asserted at beat 2 of a 5-beat packet, then released -> all outputs at reset values; the next packet arbitrates with port 0 priority.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-port Avalon-ST packet arbiter.
// Holds the arbiter state encoding and the requester count.
package avalon_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data beat with packet framing and ready backpressure.
// The master drives the beat; the slave answers with rdy.
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) ();

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               rdy;

  modport master (output data, output valid, output sop, output eop, output empty, input rdy);
  modport slave  (input data, input valid, input sop, input eop, input empty, output rdy);

endinterface

// File: rtl/avalon_arb_rr_picker.sv
// Two-way round-robin winner selection, purely combinational.
// On a tie the port that did not win last time is chosen.
module avalon_arb_rr_picker
  import avalon_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic                 gnt_vld,
  output logic                 gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-granular arbiter merging two Avalon-ST streams onto one output.
// A grant is held from sop through the accepted eop beat; stray beats in IDLE are dropped.
module avalon_st_packet_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  avalon_st_if.slave       in0,
  avalon_st_if.slave       in1,
  avalon_st_if.master      arb_out,
  output logic             stray_drop,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt0_q, cnt0_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d;
  logic                 busy_q, busy_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] stray;
  logic [NUM_PORTS-1:0] rdy_c;
  logic                 stray_c;
  logic                 gnt_vld;
  logic                 gnt_idx;

  assign req   = {in1.valid & in1.sop,  in0.valid & in0.sop};
  assign stray = {in1.valid & ~in1.sop, in0.valid & ~in0.sop};

  avalon_arb_rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    rdy_c         = '0;
    stray_c       = 1'b0;
    arb_out.data  = '0;
    arb_out.valid = 1'b0;
    arb_out.sop   = 1'b0;
    arb_out.eop   = 1'b0;
    arb_out.empty = '0;

    case (state_q)
      IDLE: begin
        // Requesting ports keep their first beat upstream; only strays are consumed.
        rdy_c   = stray;
        stray_c = |stray;
        if (gnt_vld) begin
          state_d = gnt_idx ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        arb_out.data  = in0.data;
        arb_out.valid = in0.valid;
        arb_out.sop   = in0.sop;
        arb_out.eop   = in0.eop;
        arb_out.empty = in0.empty;
        rdy_c[0]      = arb_out.rdy;
        if (in0.valid && arb_out.rdy && in0.eop) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          cnt0_d       = cnt0_q + CNT_W'(1);
        end
      end
      GRANT1: begin
        arb_out.data  = in1.data;
        arb_out.valid = in1.valid;
        arb_out.sop   = in1.sop;
        arb_out.eop   = in1.eop;
        arb_out.empty = in1.empty;
        rdy_c[1]      = arb_out.rdy;
        if (in1.valid && arb_out.rdy && in1.eop) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          cnt1_d       = cnt1_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      busy_q       <= busy_d;
    end
  end

  // Handshake outputs are forced quiet while reset is held, even for stray beats.
  assign in0.rdy    = rdy_c[0] & rst;
  assign in1.rdy    = rdy_c[1] & rst;
  assign stray_drop = stray_c & rst;
  assign pkt_cnt0   = cnt0_q;
  assign pkt_cnt1   = cnt1_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Directed bench for avalon_st_packet_arbiter: queued sources, an always-ready or
// stalled sink, and per-scenario tasks comparing against hand-derived expectations.
module tb_avalon_st_packet_arbiter;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        valid;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sink_rdy = 1'b1;
  logic             stray_drop;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) in0_if ();
  avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) in1_if ();
  avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) arb_if ();

  assign arb_if.rdy = sink_rdy;

  avalon_st_packet_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in0        (in0_if),
    .in1        (in1_if),
    .arb_out    (arb_if),
    .stray_drop (stray_drop),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  outq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    stray_cnt = 0;
  int    rdy0_hi = 0;
  int    vld_cnt = 0;

  function automatic beat_t mk(logic [31:0] d, logic s, logic e, logic [1:0] em);
    beat_t b;
    b.data  = d;
    b.sop   = s;
    b.eop   = e;
    b.empty = em;
    b.valid = 1'b1;
    return b;
  endfunction

  task automatic push_pkt(int port, logic [31:0] base, int len, logic [1:0] last_empty);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b = mk(base + 32'(i), i == 0, i == len - 1, (i == len - 1) ? last_empty : 2'd0);
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
    end
  endtask

  task automatic drive_heads();
    if (q0.size() > 0) begin
      in0_if.data = q0[0].data; in0_if.valid = q0[0].valid;
      in0_if.sop  = q0[0].sop;  in0_if.eop   = q0[0].eop; in0_if.empty = q0[0].empty;
    end else begin
      in0_if.data = '0; in0_if.valid = 1'b0; in0_if.sop = 1'b0; in0_if.eop = 1'b0; in0_if.empty = '0;
    end
    if (q1.size() > 0) begin
      in1_if.data = q1[0].data; in1_if.valid = q1[0].valid;
      in1_if.sop  = q1[0].sop;  in1_if.eop   = q1[0].eop; in1_if.empty = q1[0].empty;
    end else begin
      in1_if.data = '0; in1_if.valid = 1'b0; in1_if.sop = 1'b0; in1_if.eop = 1'b0; in1_if.empty = '0;
    end
  endtask

  // Observe at the falling edge, then advance sources just after the rising edge.
  task automatic tick();
    logic a0, a1;
    obs_t o;
    @(negedge clk);
    a0 = in0_if.valid & in0_if.rdy;
    a1 = in1_if.valid & in1_if.rdy;
    if (arb_if.valid && arb_if.rdy) begin
      o.b = mk(arb_if.data, arb_if.sop, arb_if.eop, arb_if.empty);
      o.cyc = cyc;
      outq.push_back(o);
    end
    stray_cnt += int'(stray_drop);
    rdy0_hi   += int'(in0_if.rdy);
    vld_cnt   += int'(arb_if.valid);
    @(posedge clk);
    #1;
    cyc++;
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    drive_heads();
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0) break;
      tick();
    end
    n_checks++;
    if (!(q0.size() == 0 && q1.size() == 0 && busy === 1'b0)) begin
      n_errors++;
      $display("FAIL wait_idle: timeout q0=%0d q1=%0d busy=%b, required drained and idle",
               q0.size(), q1.size(), busy);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    drive_heads();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_heads();
    #1 rst = 1'b0;
    q0.push_back(mk(32'h1111, 1'b0, 1'b0, 2'd0));
    push_pkt(1, 32'h2222, 2, 2'd0);
    drive_heads();
    #1;
    n_checks++; if (stray_drop !== 1'b0) begin n_errors++; $display("FAIL rst_stray: got %b required 0", stray_drop); end
    n_checks++; if (in0_if.rdy !== 1'b0) begin n_errors++; $display("FAIL rst_rdy0: got %b required 0", in0_if.rdy); end
    n_checks++; if (in1_if.rdy !== 1'b0) begin n_errors++; $display("FAIL rst_rdy1: got %b required 0", in1_if.rdy); end
    n_checks++; if (arb_if.valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b required 0", arb_if.valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (pkt_cnt0 !== '0) begin n_errors++; $display("FAIL rst_cnt0: got %0d required 0", pkt_cnt0); end
    n_checks++; if (pkt_cnt1 !== '0) begin n_errors++; $display("FAIL rst_cnt1: got %0d required 0", pkt_cnt1); end
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy_held: got %b required 0", busy); end
    n_checks++; if (arb_if.valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid_held: got %b required 0", arb_if.valid); end
    q0.delete();
    q1.delete();
    drive_heads();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_port();
    int c0;
    outq.delete();
    c0 = cyc;
    push_pkt(0, 32'hA000, 3, 2'd0);
    drive_heads();
    #1;
    n_checks++; if (in0_if.rdy !== 1'b0) begin n_errors++; $display("FAIL sp_hold_rdy0: got %b required 0", in0_if.rdy); end
    n_checks++; if (arb_if.valid !== 1'b0) begin n_errors++; $display("FAIL sp_idle_valid: got %b required 0", arb_if.valid); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL sp_busy_on: got %b required 1", busy); end
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sp_busy_off: got %b required 0", busy); end
    n_checks++; if (pkt_cnt0 !== 16'd1) begin n_errors++; $display("FAIL sp_cnt0: got %0d required 1", pkt_cnt0); end
    n_checks++;
    if (outq.size() != 3) begin
      n_errors++; $display("FAIL sp_nbeats: got %0d required 3", outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (outq[i].b.data !== 32'hA000 + 32'(i) || outq[i].cyc != c0 + 1 + i) begin
          n_errors++;
          $display("FAIL sp_beat%0d: got data %0h at cycle %0d required %0h at cycle %0d",
                   i, outq[i].b.data, outq[i].cyc, 32'hA000 + 32'(i), c0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_both_request();
    logic [31:0] exp [6];
    exp[0] = 32'hB000; exp[1] = 32'hB001; exp[2] = 32'hC000;
    exp[3] = 32'hC001; exp[4] = 32'hB100; exp[5] = 32'hB101;
    pulse_reset();
    outq.delete();
    push_pkt(0, 32'hB000, 2, 2'd0);
    push_pkt(0, 32'hB100, 2, 2'd0);
    push_pkt(1, 32'hC000, 2, 2'd0);
    drive_heads();
    wait_idle(40);
    n_checks++;
    if (outq.size() != 6) begin
      n_errors++; $display("FAIL both_nbeats: got %0d required 6", outq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (outq[i].b.data !== exp[i]) begin
          n_errors++; $display("FAIL both_order%0d: got %0h required %0h", i, outq[i].b.data, exp[i]);
        end
      end
    end
    n_checks++; if (pkt_cnt0 !== 16'd2) begin n_errors++; $display("FAIL both_cnt0: got %0d required 2", pkt_cnt0); end
    n_checks++; if (pkt_cnt1 !== 16'd1) begin n_errors++; $display("FAIL both_cnt1: got %0d required 1", pkt_cnt1); end
  endtask

  task automatic test_backpressure();
    int guard;
    outq.delete();
    rdy0_hi = 0;
    push_pkt(1, 32'hD000, 4, 2'd0);
    drive_heads();
    tick();
    push_pkt(0, 32'hE000, 1, 2'd0);
    drive_heads();
    tick();
    sink_rdy = 1'b0;
    repeat (5) tick();
    #1;
    n_checks++; if (outq.size() != 1) begin n_errors++; $display("FAIL bp_stalled_beats: got %0d required 1", outq.size()); end
    n_checks++;
    if (arb_if.valid !== 1'b1 || arb_if.data !== 32'hD001) begin
      n_errors++; $display("FAIL bp_held_beat: got valid %b data %0h required 1 D001", arb_if.valid, arb_if.data);
    end
    sink_rdy = 1'b1;
    guard = 0;
    while (q1.size() > 0 && guard < 20) begin tick(); guard++; end
    n_checks++; if (rdy0_hi != 0) begin n_errors++; $display("FAIL bp_rdy0: got %0d high cycles required 0", rdy0_hi); end
    n_checks++;
    if (outq.size() != 4) begin
      n_errors++; $display("FAIL bp_nbeats: got %0d required 4", outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (outq[i].b.data !== 32'hD000 + 32'(i)) begin
          n_errors++; $display("FAIL bp_beat%0d: got %0h required %0h", i, outq[i].b.data, 32'hD000 + 32'(i));
        end
      end
    end
    wait_idle(20);
    n_checks++; if (pkt_cnt1 !== 16'd2) begin n_errors++; $display("FAIL bp_cnt1: got %0d required 2", pkt_cnt1); end
    n_checks++; if (pkt_cnt0 !== 16'd3) begin n_errors++; $display("FAIL bp_cnt0: got %0d required 3", pkt_cnt0); end
  endtask

  task automatic test_stray();
    stray_cnt = 0;
    vld_cnt = 0;
    q0.push_back(mk(32'h5A5A, 1'b0, 1'b0, 2'd0));
    q0.push_back(mk(32'h5A5B, 1'b0, 1'b0, 2'd0));
    drive_heads();
    #1;
    n_checks++; if (stray_drop !== 1'b1) begin n_errors++; $display("FAIL stray_pulse: got %b required 1", stray_drop); end
    n_checks++; if (in0_if.rdy !== 1'b1) begin n_errors++; $display("FAIL stray_rdy0: got %b required 1", in0_if.rdy); end
    tick(); tick(); tick();
    n_checks++; if (stray_cnt != 2) begin n_errors++; $display("FAIL stray_count: got %0d required 2", stray_cnt); end
    n_checks++; if (vld_cnt != 0) begin n_errors++; $display("FAIL stray_outvalid: got %0d valid cycles required 0", vld_cnt); end
    n_checks++; if (q0.size() != 0) begin n_errors++; $display("FAIL stray_consumed: got %0d left required 0", q0.size()); end
  endtask

  task automatic test_single_beat();
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = pkt_cnt1 + 16'd1;
    outq.delete();
    q1.push_back(mk(32'hF00D, 1'b1, 1'b1, 2'd3));
    drive_heads();
    wait_idle(10);
    n_checks++;
    if (outq.size() != 1) begin
      n_errors++; $display("FAIL sb_nbeats: got %0d required 1", outq.size());
    end else begin
      n_checks++;
      if (outq[0].b.empty !== 2'd3 || outq[0].b.sop !== 1'b1 || outq[0].b.eop !== 1'b1 || outq[0].b.data !== 32'hF00D) begin
        n_errors++;
        $display("FAIL sb_beat: got data %0h sop %b eop %b empty %0d required F00D 1 1 3",
                 outq[0].b.data, outq[0].b.sop, outq[0].b.eop, outq[0].b.empty);
      end
    end
    n_checks++; if (pkt_cnt1 !== exp_cnt) begin n_errors++; $display("FAIL sb_cnt1: got %0d required %0d", pkt_cnt1, exp_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sb_idle: got busy %b required 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    push_pkt(1, 32'h5000, 5, 2'd0);
    drive_heads();
    tick();
    tick();
    #1;
    n_checks++; if (arb_if.valid !== 1'b1) begin n_errors++; $display("FAIL rm_inflight: got valid %b required 1", arb_if.valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (arb_if.valid !== 1'b0) begin n_errors++; $display("FAIL rm_valid: got %b required 0", arb_if.valid); end
    n_checks++; if (in1_if.rdy !== 1'b0) begin n_errors++; $display("FAIL rm_rdy1: got %b required 0", in1_if.rdy); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %b required 0", busy); end
    n_checks++; if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin n_errors++; $display("FAIL rm_cnt: got %0d/%0d required 0/0", pkt_cnt0, pkt_cnt1); end
    q0.delete();
    q1.delete();
    drive_heads();
    tick();
    tick();
    n_checks++; if (pkt_cnt1 !== '0) begin n_errors++; $display("FAIL rm_cnt_held: got %0d required 0", pkt_cnt1); end
    rst = 1'b1;
    outq.delete();
    push_pkt(1, 32'h6100, 2, 2'd0);
    push_pkt(0, 32'h6000, 2, 2'd0);
    drive_heads();
    wait_idle(30);
    n_checks++;
    if (outq.size() != 4) begin
      n_errors++; $display("FAIL rm_nbeats: got %0d required 4", outq.size());
    end else begin
      n_checks++;
      if (outq[0].b.data !== 32'h6000 || outq[2].b.data !== 32'h6100) begin
        n_errors++; $display("FAIL rm_priority: got first %0h third %0h required 6000 6100", outq[0].b.data, outq[2].b.data);
      end
    end
    n_checks++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin n_errors++; $display("FAIL rm_cnt_after: got %0d/%0d required 1/1", pkt_cnt0, pkt_cnt1); end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_both_request();
    test_backpressure();
    test_stray();
    test_single_beat();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
